// File: rtl/pwm_mod.sv
// rtl/pwm_mod.sv - LED PWM generator with a shadowed, boundary-synchronised duty update
//
// Purpose:
//   Turns the brightness level from the fade/ramp generator into a PWM drive
//   for the LED pin. New duty values are taken through a valid/ready handshake
//   into a shadow register. They only take effect at a period boundary, so a
//   fade never produces a glitched or truncated pulse.
//
// Ports:
//   clk          - clock
//   reset        - asynchronous, active-high reset
//   enable       - run PWM; low forces the output inactive and restarts the period
//   duty_in      - requested duty level (WIDTH bits)
//   duty_valid   - duty_in valid
//   duty_ready   - shadow register empty, a new duty can be accepted
//   pwm_out      - PWM output (active-low when INVERT=1)
//   period_start - one-clock strobe in the clock where a new period begins
//   duty_active  - duty currently being generated (WIDTH bits)

module pwm_mod #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter bit INVERT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);

  // Prescaler width holds PRESCALE-1, with at least one bit.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  // The counter stops one short of all-ones, so a duty of all-ones is never
  // reached by cnt and gives a constantly active output.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] duty_active_q, duty_active_d;
  logic             period_start_q, period_start_d;
  logic             pwm_q, pwm_d;

  logic tick;
  logic boundary;
  logic accept;

  assign tick     = enable && (presc_q == PRESC_LAST);
  assign boundary = tick && (cnt_q == CNT_LAST);
  assign accept   = duty_valid && !pending_q;

  always_comb begin
    presc_d        = presc_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    duty_active_d  = duty_active_q;
    period_start_d = 1'b0;
    pwm_d          = INVERT;

    if (accept) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end

    if (!enable) begin
      presc_d = '0;
      cnt_d   = '0;
      // Nothing is being generated, so a waiting duty can be applied at once.
      // accept is never true here, because pending_q blocks it.
      if (pending_q) begin
        duty_active_d = shadow_q;
        pending_d     = 1'b0;
      end
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + WIDTH'(1);
      end
      // Only a value pending before this clock is applied. A value accepted
      // on the boundary clock itself waits for the next boundary.
      if (boundary) begin
        period_start_d = 1'b1;
        if (pending_q) begin
          duty_active_d = shadow_q;
          pending_d     = 1'b0;
        end
      end
      pwm_d = INVERT ^ (cnt_q < duty_active_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
      duty_active_q  <= '0;
      period_start_q <= 1'b0;
      pwm_q          <= INVERT;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      duty_active_q  <= duty_active_d;
      period_start_q <= period_start_d;
      pwm_q          <= pwm_d;
    end
  end

  assign duty_ready   = !pending_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_mod.sv
// tb/tb_pwm_mod.sv - directed self-checking bench for pwm_mod

module tb_pwm_mod;

  logic clk;
  logic reset;

  // Index 0: PRESCALE=1 INVERT=0, 1: PRESCALE=1 INVERT=1, 2: PRESCALE=4 INVERT=0
  logic [2:0]      en;
  logic [2:0]      dvalid;
  logic [2:0][7:0] din;
  logic [2:0]      ready;
  logic [2:0]      pwm;
  logic [2:0]      ps;
  logic [2:0][7:0] dact;

  int n_checks;
  int n_errors;

  pwm_mod #(.WIDTH(8), .PRESCALE(1), .INVERT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(en[0]), .duty_in(din[0]),
    .duty_valid(dvalid[0]), .duty_ready(ready[0]), .pwm_out(pwm[0]),
    .period_start(ps[0]), .duty_active(dact[0])
  );

  pwm_mod #(.WIDTH(8), .PRESCALE(1), .INVERT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(en[1]), .duty_in(din[1]),
    .duty_valid(dvalid[1]), .duty_ready(ready[1]), .pwm_out(pwm[1]),
    .period_start(ps[1]), .duty_active(dact[1])
  );

  pwm_mod #(.WIDTH(8), .PRESCALE(4), .INVERT(1'b0)) dut2 (
    .clk(clk), .reset(reset), .enable(en[2]), .duty_in(din[2]),
    .duty_valid(dvalid[2]), .duty_ready(ready[2]), .pwm_out(pwm[2]),
    .period_start(ps[2]), .duty_active(dact[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_duty(input int d, input logic [7:0] val, input string tag);
    check({tag, "_ready_before"}, 32'(ready[d]), 32'd1);
    din[d]    = val;
    dvalid[d] = 1'b1;
    step();
    dvalid[d] = 1'b0;
    check({tag, "_ready_after"}, 32'(ready[d]), 32'd0);
  endtask

  task automatic wait_ps(input int d, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      if (ps[d]) found = 1'b1;
    end
    check({tag, "_ps_seen"}, 32'(found), 32'd1);
  endtask

  // Steps n clocks, counting high pwm samples and period_start strobes.
  task automatic measure(input int d, input int n, output int hi, output int ps_n,
                         output int ps_first, output int ps_gap);
    int prev;
    hi = 0; ps_n = 0; ps_first = 0; ps_gap = 0; prev = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (pwm[d]) hi++;
      if (ps[d]) begin
        if (ps_n == 0) ps_first = i;
        else if (ps_n == 1) ps_gap = i - prev;
        prev = i;
        ps_n++;
      end
    end
  endtask

  int hi, ps_n, ps_first, ps_gap;

  initial begin
    n_checks = 0;
    n_errors = 0;
    en = '0; dvalid = '0; din = '0;
    reset = 1'b1;
    steps(3);

    // Reset state
    check("rst_pwm0", 32'(pwm[0]), 32'd0);
    check("rst_pwm1_inv", 32'(pwm[1]), 32'd1);
    check("rst_ready0", 32'(ready[0]), 32'd1);
    check("rst_dact0", 32'(dact[0]), 32'd0);
    check("rst_ps0", 32'(ps[0]), 32'd0);
    reset = 1'b0;
    steps(2);

    // 1: duty 64 applied while disabled, then one enabled run of two periods
    send_duty(0, 8'd64, "t1_send");
    step();
    check("t1_dact", 32'(dact[0]), 32'd64);
    check("t1_ready", 32'(ready[0]), 32'd1);
    check("t1_ps_idle", 32'(ps[0]), 32'd0);
    en[0] = 1'b1;
    measure(0, 510, hi, ps_n, ps_first, ps_gap);
    check("t1_hi", 32'(hi), 32'd128);
    check("t1_ps_n", 32'(ps_n), 32'd2);
    check("t1_ps_first", 32'(ps_first), 32'd255);
    check("t1_ps_gap", 32'(ps_gap), 32'd255);

    // 2: extreme duties
    send_duty(0, 8'd0, "t2_zero");
    wait_ps(0, "t2_zero");
    check("t2_zero_dact", 32'(dact[0]), 32'd0);
    measure(0, 255, hi, ps_n, ps_first, ps_gap);
    check("t2_zero_hi", 32'(hi), 32'd0);
    send_duty(0, 8'd255, "t2_full");
    wait_ps(0, "t2_full");
    check("t2_full_dact", 32'(dact[0]), 32'd255);
    measure(0, 300, hi, ps_n, ps_first, ps_gap);
    check("t2_full_hi", 32'(hi), 32'd300);

    // 2: inverted polarity on dut1
    check("t2_inv_idle", 32'(pwm[1]), 32'd1);
    en[1] = 1'b1;
    measure(1, 255, hi, ps_n, ps_first, ps_gap);
    check("t2_inv_zero_hi", 32'(hi), 32'd255);
    en[1] = 1'b0;
    step();
    send_duty(1, 8'd255, "t2_inv_full");
    step();
    check("t2_inv_full_dact", 32'(dact[1]), 32'd255);
    en[1] = 1'b1;
    measure(1, 255, hi, ps_n, ps_first, ps_gap);
    check("t2_inv_full_hi", 32'(hi), 32'd0);
    en[1] = 1'b0;

    // 3: update mid-period; a second valid while busy is dropped
    send_duty(0, 8'd64, "t3_base");
    wait_ps(0, "t3_base");
    steps(100);
    send_duty(0, 8'd200, "t3_upd");
    din[0] = 8'd7;
    dvalid[0] = 1'b1;
    step();
    dvalid[0] = 1'b0;
    check("t3_busy_ready", 32'(ready[0]), 32'd0);
    check("t3_old_dact", 32'(dact[0]), 32'd64);
    wait_ps(0, "t3_upd");
    check("t3_new_dact", 32'(dact[0]), 32'd200);
    check("t3_ready_back", 32'(ready[0]), 32'd1);
    measure(0, 255, hi, ps_n, ps_first, ps_gap);
    check("t3_hi", 32'(hi), 32'd200);
    check("t3_not7", 32'(dact[0]), 32'd200);

    // 4: accept on the boundary clock lands one period later
    wait_ps(0, "t4_align");
    steps(254);
    din[0] = 8'd128;
    dvalid[0] = 1'b1;
    step();
    dvalid[0] = 1'b0;
    check("t4_ps_on_boundary", 32'(ps[0]), 32'd1);
    check("t4_dact_kept", 32'(dact[0]), 32'd200);
    check("t4_pending", 32'(ready[0]), 32'd0);
    measure(0, 255, hi, ps_n, ps_first, ps_gap);
    check("t4_old_hi", 32'(hi), 32'd200);
    check("t4_new_dact", 32'(dact[0]), 32'd128);
    measure(0, 255, hi, ps_n, ps_first, ps_gap);
    check("t4_new_hi", 32'(hi), 32'd128);

    // 5: PRESCALE=4
    send_duty(2, 8'd10, "t5_send");
    step();
    check("t5_dact", 32'(dact[2]), 32'd10);
    en[2] = 1'b1;
    measure(2, 2040, hi, ps_n, ps_first, ps_gap);
    check("t5_hi", 32'(hi), 32'd80);
    check("t5_ps_n", 32'(ps_n), 32'd2);
    check("t5_ps_first", 32'(ps_first), 32'd1020);
    check("t5_ps_gap", 32'(ps_gap), 32'd1020);
    en[2] = 1'b0;

    // 6: reset mid-period with a pending duty
    wait_ps(0, "t6_align");
    steps(50);
    send_duty(0, 8'd99, "t6_pend");
    steps(10);
    check("t6_pwm_before", 32'(pwm[0]), 32'd1);
    reset = 1'b1;
    #2;
    check("t6_pwm", 32'(pwm[0]), 32'd0);
    check("t6_pwm_inv", 32'(pwm[1]), 32'd1);
    check("t6_dact", 32'(dact[0]), 32'd0);
    check("t6_ready", 32'(ready[0]), 32'd1);
    check("t6_ps", 32'(ps[0]), 32'd0);
    steps(2);
    reset = 1'b0;
    measure(0, 510, hi, ps_n, ps_first, ps_gap);
    check("t6_hi_after", 32'(hi), 32'd0);
    check("t6_dact_after", 32'(dact[0]), 32'd0);
    check("t6_ps_after", 32'(ps_n), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
